lfsr_rand_range: RTL and testbench

//  Parametrised Fibonacci LFSR with a request/valid draw engine. Returns uniformly

---
 rtl/lfsr_rand_range.sv | 133 +++++++++++++
 tb/tb_lfsr_rand_range.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_range.sv
// Fibonacci LFSR with a req/valid draw engine returning values in [0, RANGE-1].
// Ports: clk, rst (sync, active-low), req, rdy, valid, num, q; seed_ld/seed_in
// exist only when LFSR_SEED_LOAD_EN is defined.
module lfsr_rand_range #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'h8016,
  parameter logic [WIDTH-1:0] SEED  = 16'hFFFF,
  parameter int unsigned      OUT_W = 5,
  parameter int unsigned      RANGE = 26,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
`ifdef LFSR_SEED_LOAD_EN
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
`endif
  output logic             rdy,
  output logic             valid,
  output logic [OUT_W-1:0] num,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned CW = $clog2(STEPS + 1);

  // One extra bit so RANGE = 2**OUT_W is representable and never rejects.
  localparam logic [OUT_W:0] RNG = (OUT_W + 1)'(RANGE);
  localparam logic [CW-1:0]  LAST = CW'(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    cnt_inc;
  logic [OUT_W-1:0] num_n;
  logic             valid_n;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] lfsr_adv;
  logic [OUT_W-1:0] cand;
  logic             accept;

  assign fb       = ^(lfsr & TAPS);
  assign shifted  = {lfsr[WIDTH-2:0], fb};
  // Never let the register settle into the all-zero lock-up state.
  assign lfsr_adv = (shifted == '0) ? SEED : shifted;
  assign cand     = lfsr[OUT_W-1:0];
  assign accept   = {1'b0, cand} < RNG;
  assign cnt_inc  = cnt + 1'b1;

  assign rdy   = (state == IDLE);
  assign q     = lfsr;

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    num_n   = num;
    valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        lfsr_n = lfsr_adv;
        cnt_n  = cnt_inc;
        if (cnt_inc == LAST) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          num_n   = cand;
          valid_n = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
`ifdef LFSR_SEED_LOAD_EN
    // Seed load aborts any draw and leaves the last result untouched.
    if (seed_ld) begin
      lfsr_n  = (seed_in == '0) ? SEED : seed_in;
      state_n = IDLE;
      cnt_n   = '0;
      num_n   = num;
      valid_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr  <= SEED;
      cnt   <= '0;
      num   <= '0;
      valid <= 1'b0;
    end else begin
      lfsr  <= lfsr_n;
      cnt   <= cnt_n;
      num   <= num_n;
      valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench for lfsr_rand_range: reset, rejection draws, back-to-back,
// reset abort, RANGE=32 instance, 1000-draw coverage, optional seed load.
module tb_lfsr_rand_range;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req2 = 1'b0;
  logic        rdy, valid, rdy2, valid2;
  logic [4:0]  num, num2;
  logic [15:0] q, q2;
`ifdef LFSR_SEED_LOAD_EN
  logic        seed_ld = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic        seed_ld2 = 1'b0;
  logic [15:0] seed_in2 = 16'h0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rand_range dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef LFSR_SEED_LOAD_EN
    .seed_ld (seed_ld),
    .seed_in (seed_in),
`endif
    .rdy     (rdy),
    .valid   (valid),
    .num     (num),
    .q       (q)
  );

  lfsr_rand_range #(.RANGE(32)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
`ifdef LFSR_SEED_LOAD_EN
    .seed_ld (seed_ld2),
    .seed_in (seed_in2),
`endif
    .rdy     (rdy2),
    .valid   (valid2),
    .num     (num2),
    .q       (q2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] s);
    logic [15:0] n;
    n = {s[14:0], ^(s & 16'h8016)};
    return (n == 16'h0) ? 16'hFFFF : n;
  endfunction

  // Returns edges after the accepting edge until valid (0 = timeout).
  task automatic draw(output int lat);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (valid) lat = k;
    end
  endtask

  task automatic draw2(output int lat);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (valid2) lat = k;
    end
  endtask

  initial begin
    logic [15:0] tq[7];
    logic        tv[7];
    logic [15:0] bq[9];
    logic        bv[9];
    logic        br[9];
    logic [4:0]  bn[9];
    logic [4:0]  n2[4];
    logic        seen[32];
    logic [15:0] m;
    logic [15:0] s;
    int          rej;
    int          lat;
    int          bad;

    tq = '{16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hFFFC,
           16'hFFF9, 16'hFFF9, 16'hFFF9};
    tv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bq = '{16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hFFFC, 16'hFFF9,
           16'hFFF9, 16'hFFF9, 16'hFFF2, 16'hFFF2};
    bv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    br = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bn = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd25, 5'd25, 5'd25, 5'd18};
    n2 = '{5'd30, 5'd28, 5'd25, 5'd18};
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_q", 32'(q), 32'hFFFF);
      check("idle_rdy", 32'(rdy), 32'd1);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_num", 32'(num), 32'd0);
    end

    // Single draw with two rejections
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("d1_e0_q", 32'(q), 32'hFFFF);
    check("d1_e0_rdy", 32'(rdy), 32'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("d1_q", 32'(q), 32'(tq[k]));
      check("d1_valid", 32'(valid), 32'(tv[k]));
      check("d1_rdy", 32'(rdy), (k >= 5) ? 32'd1 : 32'd0);
      check("d1_num", 32'(num), (k >= 5) ? 32'd25 : 32'd0);
    end

    // Back-to-back with req held high
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("b2b_rst_q", 32'(q), 32'hFFFF);
    req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("b2b_q", 32'(q), 32'(bq[k]));
      check("b2b_valid", 32'(valid), 32'(bv[k]));
      check("b2b_rdy", 32'(rdy), 32'(br[k]));
      check("b2b_num", 32'(num), 32'(bn[k]));
    end
    req = 1'b0;
    @(negedge clk);
    check("b2b_end_rdy", 32'(rdy), 32'd1);
    check("b2b_end_valid", 32'(valid), 32'd0);
    check("b2b_end_q", 32'(q), 32'hFFF2);

    // Reset during SHIFT aborts the draw
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("abort_shift_rdy", 32'(rdy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_q", 32'(q), 32'hFFFF);
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_novalid", 32'(valid), 32'd0);
      check("abort_hold_q", 32'(q), 32'hFFFF);
    end

    // RANGE=32 never rejects
    for (int d = 0; d < 4; d++) begin
      draw2(lat);
      check("r32_lat", 32'(lat), 32'd2);
      check("r32_num", 32'(num2), 32'(n2[d]));
    end

    // 1000 draws against the LFSR model
    m = 16'hFFFF;
    bad = 0;
    for (int d = 0; d < 1000; d++) begin
      s = mdl(m);
      rej = 0;
      while (s[4:0] >= 5'd26) begin
        s = mdl(s);
        rej++;
      end
      draw(lat);
      check("rnd_lat", 32'(lat), 32'(2 * (rej + 1)));
      check("rnd_num", 32'(num), 32'(s[4:0]));
      check("rnd_q", 32'(q), 32'(s));
      seen[num] = 1'b1;
      if (num >= 5'd26) bad++;
      m = s;
    end
    for (int v = 0; v < 26; v++) begin
      check("rnd_seen", 32'(seen[v]), 32'd1);
    end
    check("rnd_out_of_range", 32'(bad), 32'd0);

`ifdef LFSR_SEED_LOAD_EN
    seed_in = 16'h0;
    seed_ld = 1'b1;
    @(negedge clk);
    seed_ld = 1'b0;
    check("seed0_q", 32'(q), 32'hFFFF);
    check("seed0_rdy", 32'(rdy), 32'd1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("seed_mid_q", 32'(q), 32'hFFFE);
    seed_in = 16'h0001;
    seed_ld = 1'b1;
    @(negedge clk);
    seed_ld = 1'b0;
    check("seed1_q", 32'(q), 32'h0001);
    check("seed1_rdy", 32'(rdy), 32'd1);
    check("seed1_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("seed1_novalid", 32'(valid), 32'd0);
    draw(lat);
    check("seed1_lat", 32'(lat), 32'd2);
    check("seed1_num", 32'(num), 32'd2);
    check("seed1_qnext", 32'(q), 32'h0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
